// File: rtl/vdma_read_burst_responder_if.sv
// Signal bundle between the read-FIFO status controller, the AXI4 read channels and the
// read-side pixel FIFO. The responder uses the slave modport, its environment uses master.
interface vdma_read_burst_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LSIZE      = 9
) ();
    logic                  fsync;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  burst_req;
    logic                  tail_req;
    logic [LSIZE-1:0]      req_len;
    logic                  resp;
    logic                  done;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  err;

    modport slave (
        input  fsync, base_addr, burst_req, tail_req, req_len,
        input  arready, rdata, rresp, rlast, rvalid, fifo_full,
        output resp, done, busy, araddr, arlen, arvalid, rready,
        output fifo_wr_en, fifo_wr_data, err
    );

    modport master (
        output fsync, base_addr, burst_req, tail_req, req_len,
        output arready, rdata, rresp, rlast, rvalid, fifo_full,
        input  resp, done, busy, araddr, arlen, arvalid, rready,
        input  fifo_wr_en, fifo_wr_data, err
    );
endinterface

// File: rtl/vdma_read_burst_responder.sv
// Turns each burst/tail request into one AXI4 read burst and streams the returned beats into
// the pixel FIFO, tracking a running frame address that reloads from base_addr on fsync.
module vdma_read_burst_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LSIZE      = 9
) (
    input  logic                        clock,
    input  logic                        rst,
    vdma_read_burst_responder_if.slave  bus
);
    localparam int unsigned Bpb = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StFin} state_e;

    state_e                state_q, state_d;
    logic [LSIZE-1:0]      len_q, len_d;
    logic [LSIZE-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  arvalid_q, arvalid_d;
    logic                  resp_q, resp_d;
    logic                  done_q, done_d;
    logic                  flush_q, flush_d;
    logic                  err_q, err_d;

    logic rready_c, beat_c, last_beat_c;

    // While flushing an aborted frame, beats are drained regardless of FIFO space.
    assign rready_c    = (state_q == StData) && (!bus.fifo_full || flush_q);
    assign beat_c      = rready_c && bus.rvalid;
    assign last_beat_c = (beat_cnt_q == len_q - LSIZE'(1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        cur_addr_d = cur_addr_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arvalid_d  = arvalid_q;
        flush_d    = flush_q;
        err_d      = err_q;
        resp_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.fsync) begin
                    cur_addr_d = bus.base_addr;
                end
                // Both request kinds share req_len, so burst_req priority needs no mux.
                if (bus.burst_req || bus.tail_req) begin
                    len_d      = bus.req_len;
                    beat_cnt_d = '0;
                    resp_d     = 1'b1;
                    if (bus.req_len == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d   = StAddr;
                        arvalid_d = 1'b1;
                        araddr_d  = bus.fsync ? bus.base_addr : cur_addr_q;
                        arlen_d   = 8'(bus.req_len - LSIZE'(1));
                    end
                end
            end
            StAddr: begin
                if (bus.fsync) begin
                    flush_d = 1'b1;
                end
                if (bus.arready) begin
                    arvalid_d  = 1'b0;
                    state_d    = StData;
                    cur_addr_d = cur_addr_q + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(Bpb);
                end
            end
            StData: begin
                if (bus.fsync) begin
                    flush_d = 1'b1;
                end
                if (beat_c) begin
                    beat_cnt_d = beat_cnt_q + LSIZE'(1);
                    if ((bus.rresp != 2'b00) || (bus.rlast != last_beat_c)) begin
                        err_d = 1'b1;
                    end
                    if (last_beat_c) begin
                        state_d = StFin;
                        done_d  = !flush_d;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                // A zero-length request reports done one cycle after its resp.
                if ((len_q == '0) && !flush_q) begin
                    done_d = 1'b1;
                end
                if (flush_q) begin
                    cur_addr_d = bus.base_addr;
                    flush_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            beat_cnt_q <= '0;
            cur_addr_q <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arvalid_q  <= 1'b0;
            resp_q     <= 1'b0;
            done_q     <= 1'b0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            cur_addr_q <= cur_addr_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arvalid_q  <= arvalid_d;
            resp_q     <= resp_d;
            done_q     <= done_d;
            flush_q    <= flush_d;
            err_q      <= err_d;
        end
    end

    assign bus.resp         = resp_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.araddr       = araddr_q;
    assign bus.arlen        = arlen_q;
    assign bus.arvalid      = arvalid_q;
    assign bus.rready       = rready_c;
    assign bus.fifo_wr_en   = beat_c && !flush_q;
    assign bus.fifo_wr_data = bus.rdata;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_vdma_read_burst_responder.sv
// Directed bench for vdma_read_burst_responder: a table of request scenarios with
// hand-computed AR fields, write/beat/done counts and error state, plus reset sequences.
module tb_vdma_read_burst_responder;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;
    localparam int unsigned LS = 9;

    logic clock;
    logic rst;

    vdma_read_burst_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSIZE(LS)) bus ();

    vdma_read_burst_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSIZE(LS)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          rst_b;
        bit          fs;
        logic [31:0] base;
        bit          burst;
        bit          tail;
        int          len;
        int          full_per;
        int          fs_beat;
        int          bad_resp;
        int          bad_last;
        logic [31:0] exp_araddr;
        int          exp_arlen;
        bit          exp_ar;
        int          exp_writes;
        int          exp_beats;
        int          exp_done;
        bit          exp_err;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    int wr_cnt = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int full_wr = 0;
    int order_bad = 0;
    int wr_base = 0;
    int salt = 0;

    function automatic logic [DW-1:0] pat(input int s, input int k);
        logic [31:0] w;
        w = 32'(s * 1000 + k) ^ 32'h5A5A_0000;
        return {8{w}};
    endfunction

    always @(negedge clock) begin
        if (bus.done) done_cnt++;
        if (bus.rvalid && bus.rready) beat_cnt++;
        if (bus.fifo_wr_en) begin
            if (bus.fifo_full) full_wr++;
            if (bus.fifo_wr_data !== pat(salt, wr_cnt - wr_base)) order_bad++;
            wr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int w0, b0, d0, f0, o0, k, cyc;
        logic acc;
        if (v.rst_b) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        base_addr_drive(v.base);
        bus.fsync     = v.fs;
        bus.burst_req = v.burst;
        bus.tail_req  = v.tail;
        bus.req_len   = LS'(v.len);
        salt++;
        wr_base = wr_cnt;
        w0 = wr_cnt; b0 = beat_cnt; d0 = done_cnt; f0 = full_wr; o0 = order_bad;
        tick();
        bus.fsync = 1'b0;
        chk("resp", 64'(bus.resp), 64'(1));
        chk("arvalid", 64'(bus.arvalid), 64'(v.exp_ar));
        if (v.exp_ar) begin
            chk("araddr", 64'(bus.araddr), 64'(v.exp_araddr));
            chk("arlen", 64'(bus.arlen), 64'(v.exp_arlen));
        end
        bus.burst_req = 1'b0;
        bus.tail_req  = 1'b0;
        tick();
        chk("resp_pulse", 64'(bus.resp), 64'(0));
        chk("ar_hold", 64'(bus.arvalid), 64'(v.exp_ar));
        bus.arready = v.exp_ar;
        tick();
        bus.arready = 1'b0;
        k = 0;
        cyc = 0;
        while (k < v.len && cyc < 2000) begin
            bus.rvalid    = 1'b1;
            bus.rdata     = pat(salt, k);
            bus.rlast     = (v.bad_last >= 0) ? (k == v.bad_last) : (k == v.len - 1);
            bus.rresp     = (k == v.bad_resp) ? 2'b10 : 2'b00;
            bus.fifo_full = (v.full_per != 0) && (((cyc / v.full_per) % 2) == 1);
            bus.fsync     = (k == v.fs_beat);
            #1;
            acc = bus.rready;
            tick();
            if (acc) k++;
            cyc++;
        end
        chk("beats_sent", 64'(k), 64'(v.len));
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
        bus.fifo_full = 1'b0; bus.fsync = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("idle", 64'(bus.busy), 64'(0));
        tick();
        tick();
        chk("writes", 64'(wr_cnt - w0), 64'(v.exp_writes));
        chk("beats", 64'(beat_cnt - b0), 64'(v.exp_beats));
        chk("dones", 64'(done_cnt - d0), 64'(v.exp_done));
        chk("full_writes", 64'(full_wr - f0), 64'(0));
        chk("data_order", 64'(order_bad - o0), 64'(0));
        chk("err", 64'(bus.err), 64'(v.exp_err));
    endtask

    task automatic base_addr_drive(input logic [31:0] a);
        bus.base_addr = a;
    endtask

    vec_t vecs[11];
    vec_t rv;

    initial begin
        // rst fs base burst tail len fper fsb bresp blast araddr arlen ar wr beats done err
        vecs[0]  = '{0, 0, 32'h1000, 1, 0, 100, 0, -1, -1, -1, 32'h1000, 99, 1, 100, 100, 1, 0};
        vecs[1]  = '{0, 0, 32'h1000, 1, 0, 16, 3, -1, -1, -1, 32'h1C80, 15, 1, 16, 16, 1, 0};
        vecs[2]  = '{0, 0, 32'h1000, 0, 1, 0, 0, -1, -1, -1, 32'h0, 0, 0, 0, 0, 1, 0};
        vecs[3]  = '{0, 0, 32'h1000, 0, 1, 1, 0, -1, -1, -1, 32'h1E80, 0, 1, 1, 1, 1, 0};
        vecs[4]  = '{0, 0, 32'h1000, 1, 0, 256, 0, -1, -1, -1, 32'h1EA0, 255, 1, 256, 256, 1, 0};
        vecs[5]  = '{0, 0, 32'h1000, 1, 1, 4, 0, -1, -1, -1, 32'h3EA0, 3, 1, 4, 4, 1, 0};
        vecs[6]  = '{0, 1, 32'h8000, 1, 0, 2, 0, -1, -1, -1, 32'h8000, 1, 1, 2, 2, 1, 0};
        vecs[7]  = '{0, 0, 32'h2000, 1, 0, 64, 0, 9, -1, -1, 32'h8040, 63, 1, 10, 64, 0, 0};
        vecs[8]  = '{0, 0, 32'h2000, 1, 0, 8, 0, -1, -1, 4, 32'h2000, 7, 1, 8, 8, 1, 1};
        vecs[9]  = '{1, 0, 32'h2000, 1, 0, 8, 0, -1, 3, -1, 32'h0000, 7, 1, 8, 8, 1, 1};
        vecs[10] = '{0, 0, 32'h2000, 1, 0, 3, 0, -1, -1, -1, 32'h0100, 2, 1, 3, 3, 1, 1};

        rst = 1'b1;
        bus.fsync = 1'b0; bus.base_addr = '0; bus.burst_req = 1'b0; bus.tail_req = 1'b0;
        bus.req_len = '0; bus.arready = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        bus.rlast = 1'b0; bus.rvalid = 1'b0; bus.fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_resp", 64'(bus.resp), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_arvalid", 64'(bus.arvalid), 64'(0));
        chk("rst_rready", 64'(bus.rready), 64'(0));
        chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));

        bus.base_addr = 32'h1000;
        bus.fsync = 1'b1;
        tick();
        bus.fsync = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a burst: 5 of 32 beats delivered, then rst.
        bus.burst_req = 1'b1;
        bus.req_len = 9'd32;
        salt++;
        wr_base = wr_cnt;
        tick();
        bus.burst_req = 1'b0;
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        chk("mid_busy", 64'(bus.busy), 64'(1));
        for (int i = 0; i < 5; i++) begin
            bus.rvalid = 1'b1;
            bus.rdata = pat(salt, i);
            tick();
        end
        bus.rvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_resp", 64'(bus.resp), 64'(0));
        chk("mrst_done", 64'(bus.done), 64'(0));
        chk("mrst_busy", 64'(bus.busy), 64'(0));
        chk("mrst_arvalid", 64'(bus.arvalid), 64'(0));
        chk("mrst_rready", 64'(bus.rready), 64'(0));
        chk("mrst_wr_en", 64'(bus.fifo_wr_en), 64'(0));
        chk("mrst_err", 64'(bus.err), 64'(0));

        rv = '{0, 0, 32'h2000, 1, 0, 4, 0, -1, -1, -1, 32'h0000, 3, 1, 4, 4, 1, 0};
        run_vec(rv);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
